// File: rtl/frame_draw_sequencer.sv
// Per-frame draw scheduler: snapshots sprite slots, clears the screen one pixel per clock,
// then hands each enabled, on-screen sprite to a tiledrawer through a start/done handshake.
module frame_draw_sequencer #(
    parameter int                     NUM_SPRITES  = 4,
    parameter int                     POS_W        = 5,
    parameter int                     TILE_SHIFT   = 3,
    parameter int                     SCR_W        = 160,
    parameter int                     SCR_H        = 120,
    parameter int                     COLOUR_W     = 24,
    parameter logic [COLOUR_W-1:0]    CLEAR_COLOUR = '0,
    parameter int                     TIMEOUT      = 4096
) (
    input  logic                         CLOCK_50,
    input  logic                         frame_reset,
    input  logic [NUM_SPRITES*POS_W-1:0] spr_x,
    input  logic [NUM_SPRITES*POS_W-1:0] spr_y,
    input  logic [NUM_SPRITES*12-1:0]    spr_tile,
    input  logic [NUM_SPRITES-1:0]       spr_en,
    output logic                         tile_start,
    output logic [11:0]                  tile_addr,
    output logic [7:0]                   tile_px,
    output logic [7:0]                   tile_py,
    input  logic                         tile_done,
    output logic                         bus_sel_tile,
    output logic [7:0]                   vga_x,
    output logic [6:0]                   vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot,
    output logic                         frame_done,
    output logic [3:0]                   drawn_cnt,
    output logic [3:0]                   skip_cnt,
    output logic                         timeout_err
);

    localparam int         TILE_SIZE = 1 << TILE_SHIFT;
    localparam int         PX_W      = POS_W + TILE_SHIFT;
    localparam int         TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [7:0] LAST_X    = 8'(SCR_W - 1);
    localparam logic [6:0] LAST_Y    = 7'(SCR_H - 1);
    localparam logic [3:0] END_SLOT  = 4'(NUM_SPRITES);

    typedef enum logic [2:0] {SNAP, CLEAR, SEEK, START, WAIT, DONE} state_t;

    state_t                       state;
    logic [3:0]                   slot;
    logic [TMR_W-1:0]             timer;
    logic [NUM_SPRITES*POS_W-1:0] snap_x;
    logic [NUM_SPRITES*POS_W-1:0] snap_y;
    logic [NUM_SPRITES*12-1:0]    snap_tile;
    logic [NUM_SPRITES-1:0]       snap_en;

    logic [POS_W-1:0] cur_x;
    logic [POS_W-1:0] cur_y;
    logic [11:0]      cur_tile;
    logic             cur_en;
    logic [PX_W-1:0]  cur_px;
    logic [PX_W-1:0]  cur_py;
    logic             off_screen;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_x    = '0;
        cur_y    = '0;
        cur_tile = '0;
        cur_en   = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (slot == 4'(i)) begin
                cur_x    = snap_x[i*POS_W +: POS_W];
                cur_y    = snap_y[i*POS_W +: POS_W];
                cur_tile = snap_tile[i*12 +: 12];
                cur_en   = snap_en[i];
            end
        end
        cur_px     = {cur_x, {TILE_SHIFT{1'b0}}};
        cur_py     = {cur_y, {TILE_SHIFT{1'b0}}};
        off_screen = (int'(cur_px) + TILE_SIZE > SCR_W) || (int'(cur_py) + TILE_SIZE > SCR_H);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: snapshot registers are left out of the reset branch so reset holds their contents.
    always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
        if (frame_reset) begin
            state        <= SNAP;
            slot         <= '0;
            timer        <= '0;
            tile_start   <= 1'b0;
            tile_addr    <= '0;
            tile_px      <= '0;
            tile_py      <= '0;
            bus_sel_tile <= 1'b0;
            vga_x        <= '0;
            vga_y        <= '0;
            vga_colour   <= '0;
            vga_plot     <= 1'b0;
            frame_done   <= 1'b0;
            drawn_cnt    <= '0;
            skip_cnt     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                SNAP: begin
                    snap_x    <= spr_x;
                    snap_y    <= spr_y;
                    snap_tile <= spr_tile;
                    snap_en   <= spr_en;
                    state     <= CLEAR;
                end
                CLEAR: begin
                    // vga_plot low here means this is the first CLEAR cycle.
                    if (!vga_plot) begin
                        vga_plot   <= 1'b1;
                        vga_colour <= CLEAR_COLOUR;
                        vga_x      <= '0;
                        vga_y      <= '0;
                    end else if (vga_x == LAST_X) begin
                        vga_x <= '0;
                        if (vga_y == LAST_Y) begin
                            vga_plot   <= 1'b0;
                            vga_colour <= '0;
                            vga_y      <= '0;
                            state      <= SEEK;
                        end else begin
                            vga_y <= vga_y + 7'd1;
                        end
                    end else begin
                        vga_x <= vga_x + 8'd1;
                    end
                end
                SEEK: begin
                    if (slot == END_SLOT) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else if (!cur_en) begin
                        slot <= slot + 4'd1;
                    end else if (off_screen) begin
                        skip_cnt <= sat_inc(skip_cnt);
                        slot     <= slot + 4'd1;
                    end else begin
                        tile_addr    <= cur_tile;
                        tile_px      <= 8'(cur_px);
                        tile_py      <= 8'(cur_py);
                        tile_start   <= 1'b1;
                        bus_sel_tile <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    tile_start <= 1'b0;
                    timer      <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (tile_done) begin
                        drawn_cnt    <= sat_inc(drawn_cnt);
                        bus_sel_tile <= 1'b0;
                        slot         <= slot + 4'd1;
                        state        <= SEEK;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        timeout_err  <= 1'b1;
                        skip_cnt     <= sat_inc(skip_cnt);
                        bus_sel_tile <= 1'b0;
                        slot         <= slot + 4'd1;
                        state        <= SEEK;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DONE: state <= DONE;
                default: state <= SNAP;
            endcase
        end
    end

endmodule
